dfp_arbiter: RTL and testbench
==============================

// Module: dfp_arbiter
// PURPOSE
//  Shares one 256-bit line-granular memory port between the I-cache and D-cache downward-facing ports.
//  Sits between both caches' dfp_* interfaces and the single memory/burst adapter.
//  Arbitrates whole line transactions (one read or one write, held until resp) and routes mem_rdata/mem_resp back to the granted cache only.
// PARAMETERS
//  ADDR_W   32   address width, line-aligned (low 5 bits passed through unmodified)
//  LINE_W   256  line data width
//  PRIO_D   1    fixed-priority winner on a simultaneous request: 1 = D-cache, 0 = I-cache
// PORTS
//  clk         in   1       clock
//  rst_n       in   1       reset, asynchronous, active-low
//  i_dfp_addr  in   ADDR_W  I-cache request address
//  i_dfp_read  in   1       I-cache line read request, held high until i_dfp_resp
//  i_dfp_write in   1       I-cache line write request (tied 0 in current design, still arbitrated)
//  i_dfp_wdata in   LINE_W  I-cache write line
//  i_dfp_rdata out  LINE_W  read line returned to I-cache
//  i_dfp_resp  out  1       I-cache transaction complete, 1-cycle pulse
//  d_dfp_*     same set as i_dfp_* for the D-cache (addr, read, write, wdata, rdata, resp)
//  mem_addr    out  ADDR_W  to memory
//  mem_read    out  1       to memory, held until mem_resp
//  mem_write   out  1       to memory, held until mem_resp
//  mem_wdata   out  LINE_W  to memory
//  mem_rdata   in   LINE_W  from memory, valid with mem_resp
//  mem_resp    in   1       from memory, 1-cycle completion pulse
// BEHAVIOUR
//  - FSM (arb_state_t): IDLE, GRANT_I, GRANT_D. Reset (rst_n=0, async) -> IDLE; last_grant <= GNT_I.
//  - Reset outputs: mem_read=0, mem_write=0, i/d_dfp_resp=0; mem_addr/mem_wdata/rdata drive 0.
//  - IDLE: no mem_* request driven. Requester r is requesting when r_read|r_write.
//    - One requester -> GRANT_r next edge.
//    - Both requesting -> winner per PRIO_D; loser keeps waiting (its request stays held).
//  - GRANT_r: mem_addr/read/write/wdata = r's live inputs (combinational). Caches hold these stable until resp.
//    - r_dfp_rdata = mem_rdata; r_dfp_resp = mem_resp. The other port's resp = 0 and rdata = 0.
//    - On mem_resp: -> IDLE; last_grant <= r.
//  - Latency: request seen at edge N -> mem_read/write high from cycle N+1 -> resp in the same cycle as mem_resp.
//  - Mandatory IDLE cycle between transactions, so the memory sees request low for >=1 cycle after each resp.
//  - Granted requester deasserting before mem_resp is a protocol violation.
//    - Arbiter stays in GRANT_r until mem_resp; mem_read/write follow the live input; simulation assertion fires.
//  - r_read & r_write both high is illegal: assertion; write takes precedence on mem_* outputs.
//  - mem_resp while IDLE: ignored; no resp forwarded; assertion.
//  - Reset mid-transaction: immediate return to IDLE, mem_read/write drop. Memory model must abandon the transaction.
//  - No combinational path from mem_resp to any mem_* request output.
// CONFIGURATION
//  DFP_ARB_RR_EN defined: simultaneous requests resolved round-robin.
//    - Winner = requester != last_grant; PRIO_D is ignored.
//    - Guarantees no starvation: each side waits at most one transaction.
//  DFP_ARB_RR_EN undefined: fixed priority per PRIO_D.
//    - last_grant register is still kept; it is not used for selection.
// STRUCTURE
//  dfp_arb_pkg: arb_state_t enum {IDLE, GRANT_I, GRANT_D}; gnt_t enum {GNT_I, GNT_D}; LINE_W/ADDR_W defaults.
//  Sub-module dfp_arb_pick (combinational): req_i, req_d, last_grant -> winner.
//    - Contains the only DFP_ARB_RR_EN-dependent logic.
//  Top holds the FSM, last_grant and the output muxes.
// TESTING
//  1 Reset: rst_n=0 asynchronously mid-cycle -> mem_read=mem_write=0 and both resp=0 before the next edge; state IDLE.
//  2 Single I read, addr 0x0000_1040: mem_read high 1 cycle later with mem_addr=0x0000_1040.
//    - mem_resp after 5 cycles with rdata=0xA5..A5 -> i_dfp_resp pulse, i_dfp_rdata=0xA5..A5, d_dfp_resp stays 0.
//  3 Simultaneous I read 0x100 and D write 0x200 (wdata=0x1234..), PRIO_D=1, RR off:
//    - D is served first (mem_write, addr 0x200); after resp, one IDLE cycle; then I read at 0x100.
//  4 RR on, D requests continuously, I requests at cycle 2: grants alternate D, I, D.
//    - I waits at most one D transaction.
//  5 rst_n=0 while GRANT_D waits for mem_resp: mem_write drops; a later mem_resp is not forwarded; next I request is served normally.
//  6 Back-to-back D reads: mem_read is low for exactly 1 cycle between the two transactions; each gets exactly one resp pulse.

Source files
------------

// File: rtl/dfp_arb_pkg.sv
`default_nettype none
//==============================================================================
// Module      : dfp_arb_pkg
// Description : Shared types and default widths for the I/D-cache line-port
//               arbiter (dfp_arbiter, dfp_arb_pick).
// Revision    : 1.0 - initial release
//==============================================================================
package dfp_arb_pkg;

    localparam int C_ADDR_W_DFLT = 32;
    localparam int C_LINE_W_DFLT = 256;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } arb_state_t;

    typedef enum logic [0:0] {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } gnt_t;

endpackage : dfp_arb_pkg
`default_nettype wire

// File: rtl/dfp_arb_pick.sv
`default_nettype none
//==============================================================================
// Module      : dfp_arb_pick
// Description : Combinational winner select between I and D requesters.
//               DFP_ARB_RR_EN defined   -> round-robin against last grant.
//               DFP_ARB_RR_EN undefined -> fixed priority per PRIO_D.
// Revision    : 1.0 - initial release
//==============================================================================
module dfp_arb_pick
    import dfp_arb_pkg::*;
#(
    parameter int PRIO_D = 1
) (
    input  logic i_req_i,
    input  logic i_req_d,
    input  gnt_t i_last_grant,
    output gnt_t o_winner
);

`ifdef DFP_ARB_RR_EN
    localparam int c_unused_prio = PRIO_D;

    always_comb begin
        o_winner = GNT_I;
        if (i_req_i && i_req_d) begin
            // Whoever was served last yields, so neither side can starve.
            if (i_last_grant == GNT_I) begin
                o_winner = GNT_D;
            end else begin
                o_winner = GNT_I;
            end
        end else if (i_req_d) begin
            o_winner = GNT_D;
        end
    end
`else
    logic w_unused_last;
    assign w_unused_last = i_last_grant;

    always_comb begin
        o_winner = GNT_I;
        if (i_req_i && i_req_d) begin
            if (PRIO_D != 0) begin
                o_winner = GNT_D;
            end else begin
                o_winner = GNT_I;
            end
        end else if (i_req_d) begin
            o_winner = GNT_D;
        end
    end
`endif

endmodule : dfp_arb_pick
`default_nettype wire

// File: rtl/dfp_arbiter.sv
`default_nettype none
//==============================================================================
// Module      : dfp_arbiter
// Description : Shares one line-granular memory port between the I-cache and
//               D-cache dfp ports; whole-line transactions, resp routed back
//               to the granted cache only. Option macro: DFP_ARB_RR_EN.
// Revision    : 1.0 - initial release
//==============================================================================
module dfp_arbiter
    import dfp_arb_pkg::*;
#(
    parameter int ADDR_W = C_ADDR_W_DFLT,
    parameter int LINE_W = C_LINE_W_DFLT,
    parameter int PRIO_D = 1
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic [ADDR_W-1:0] i_dfp_addr,
    input  logic              i_dfp_read,
    input  logic              i_dfp_write,
    input  logic [LINE_W-1:0] i_dfp_wdata,
    output logic [LINE_W-1:0] i_dfp_rdata,
    output logic              i_dfp_resp,

    input  logic [ADDR_W-1:0] d_dfp_addr,
    input  logic              d_dfp_read,
    input  logic              d_dfp_write,
    input  logic [LINE_W-1:0] d_dfp_wdata,
    output logic [LINE_W-1:0] d_dfp_rdata,
    output logic              d_dfp_resp,

    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    arb_state_t r_state;
    arb_state_t w_state_nxt;
    gnt_t       r_last_grant;
    gnt_t       w_winner;
    logic       w_req_i;
    logic       w_req_d;

    assign w_req_i = i_dfp_read | i_dfp_write;
    assign w_req_d = d_dfp_read | d_dfp_write;

    dfp_arb_pick #(
        .PRIO_D       (PRIO_D)
    ) u_pick (
        .i_req_i      (w_req_i),
        .i_req_d      (w_req_d),
        .i_last_grant (r_last_grant),
        .o_winner     (w_winner)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_last_grant <= GNT_I;
        end else begin
            r_state <= w_state_nxt;
            if (mem_resp) begin
                if (r_state == GRANT_I) begin
                    r_last_grant <= GNT_I;
                end else if (r_state == GRANT_D) begin
                    r_last_grant <= GNT_D;
                end
            end
        end
    end

    // Request outputs depend only on state and live cache inputs, never on
    // mem_resp; returning to IDLE after resp forces one low request cycle.
    always_comb begin
        w_state_nxt = r_state;
        mem_addr    = '0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_wdata   = '0;
        i_dfp_rdata = '0;
        i_dfp_resp  = 1'b0;
        d_dfp_rdata = '0;
        d_dfp_resp  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req_i || w_req_d) begin
                    if (w_winner == GNT_D) begin
                        w_state_nxt = GRANT_D;
                    end else begin
                        w_state_nxt = GRANT_I;
                    end
                end
            end
            GRANT_I: begin
                mem_addr    = i_dfp_addr;
                mem_write   = i_dfp_write;
                mem_read    = i_dfp_read & ~i_dfp_write;
                mem_wdata   = i_dfp_wdata;
                i_dfp_rdata = mem_rdata;
                i_dfp_resp  = mem_resp;
                if (mem_resp) begin
                    w_state_nxt = IDLE;
                end
            end
            GRANT_D: begin
                mem_addr    = d_dfp_addr;
                mem_write   = d_dfp_write;
                mem_read    = d_dfp_read & ~d_dfp_write;
                mem_wdata   = d_dfp_wdata;
                d_dfp_rdata = mem_rdata;
                d_dfp_resp  = mem_resp;
                if (mem_resp) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

`ifndef SYNTHESIS
    a_i_rw_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(i_dfp_read && i_dfp_write));
    a_d_rw_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(d_dfp_read && d_dfp_write));
    a_i_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (r_state == GRANT_I) |-> w_req_i);
    a_d_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (r_state == GRANT_D) |-> w_req_d);
    a_idle_resp: assert property (@(posedge clk) disable iff (!rst_n)
        (r_state == IDLE) |-> !mem_resp);
`endif

endmodule : dfp_arbiter
`default_nettype wire

// File: tb/tb_dfp_arbiter.sv
`default_nettype none
//==============================================================================
// Module      : tb_dfp_arbiter
// Description : Directed, table-driven bench for dfp_arbiter plus hand-written
//               reset and arbitration-fairness sequences.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_dfp_arbiter;

    localparam int ADDR_W = 32;
    localparam int LINE_W = 256;
    localparam logic [LINE_W-1:0] C_MEMR = {32{8'hA5}};
    localparam logic [LINE_W-1:0] C_IW   = {8{32'hCAFE_F00D}};
    localparam logic [LINE_W-1:0] C_DW   = {8{32'h1234_5678}};

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [ADDR_W-1:0] i_dfp_addr = '0;
    logic              i_dfp_read = 1'b0;
    logic              i_dfp_write = 1'b0;
    logic [LINE_W-1:0] i_dfp_wdata = C_IW;
    logic [LINE_W-1:0] i_dfp_rdata;
    logic              i_dfp_resp;
    logic [ADDR_W-1:0] d_dfp_addr = '0;
    logic              d_dfp_read = 1'b0;
    logic              d_dfp_write = 1'b0;
    logic [LINE_W-1:0] d_dfp_wdata = C_DW;
    logic [LINE_W-1:0] d_dfp_rdata;
    logic              d_dfp_resp;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_read;
    logic              mem_write;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata = C_MEMR;
    logic              mem_resp = 1'b0;

    int checks = 0;
    int errors = 0;

    dfp_arbiter #(
        .ADDR_W      (ADDR_W),
        .LINE_W      (LINE_W),
        .PRIO_D      (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_dfp_addr  (i_dfp_addr),
        .i_dfp_read  (i_dfp_read),
        .i_dfp_write (i_dfp_write),
        .i_dfp_wdata (i_dfp_wdata),
        .i_dfp_rdata (i_dfp_rdata),
        .i_dfp_resp  (i_dfp_resp),
        .d_dfp_addr  (d_dfp_addr),
        .d_dfp_read  (d_dfp_read),
        .d_dfp_write (d_dfp_write),
        .d_dfp_wdata (d_dfp_wdata),
        .d_dfp_rdata (d_dfp_rdata),
        .d_dfp_resp  (d_dfp_resp),
        .mem_addr    (mem_addr),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_resp    (mem_resp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ir, iw, dr, dw;
        logic [31:0] ia, da;
        logic        mresp;
        logic        e_mr, e_mw;
        logic [31:0] e_ma;
        logic        e_ir, e_dr, e_gi, e_gd;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs[NV];

    function automatic vec_t mk(input logic ir, iw, dr, dw, input logic [31:0] ia, da,
                                input logic mresp, e_mr, e_mw, input logic [31:0] e_ma,
                                input logic e_ir, e_dr, e_gi, e_gd);
        vec_t v;
        v.ir = ir; v.iw = iw; v.dr = dr; v.dw = dw; v.ia = ia; v.da = da;
        v.mresp = mresp; v.e_mr = e_mr; v.e_mw = e_mw; v.e_ma = e_ma;
        v.e_ir = e_ir; v.e_dr = e_dr; v.e_gi = e_gi; v.e_gd = e_gd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [LINE_W-1:0] act,
                       input logic [LINE_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_addr [3];
        logic [LINE_W-1:0] exp_wd;
        int n;

        //            ir iw dr dw ia          da          rsp mr mw ma          ir dr gi gd
        vecs[0]  = mk(1, 0, 0, 0, 32'h1040,   32'h0,      0,  0, 0, 32'h0,      0, 0, 0, 0);
        vecs[1]  = mk(1, 0, 0, 0, 32'h1040,   32'h0,      0,  1, 0, 32'h1040,   0, 0, 1, 0);
        vecs[2]  = mk(1, 0, 0, 0, 32'h1040,   32'h0,      0,  1, 0, 32'h1040,   0, 0, 1, 0);
        vecs[3]  = mk(1, 0, 0, 0, 32'h1040,   32'h0,      0,  1, 0, 32'h1040,   0, 0, 1, 0);
        vecs[4]  = mk(1, 0, 0, 0, 32'h1040,   32'h0,      0,  1, 0, 32'h1040,   0, 0, 1, 0);
        vecs[5]  = mk(1, 0, 0, 0, 32'h1040,   32'h0,      0,  1, 0, 32'h1040,   0, 0, 1, 0);
        vecs[6]  = mk(1, 0, 0, 0, 32'h1040,   32'h0,      1,  1, 0, 32'h1040,   1, 0, 1, 0);
        vecs[7]  = mk(0, 0, 0, 0, 32'h0,      32'h0,      0,  0, 0, 32'h0,      0, 0, 0, 0);
        vecs[8]  = mk(1, 0, 0, 1, 32'h100,    32'h200,    0,  0, 0, 32'h0,      0, 0, 0, 0);
        vecs[9]  = mk(1, 0, 0, 1, 32'h100,    32'h200,    0,  0, 1, 32'h200,    0, 0, 0, 1);
        vecs[10] = mk(1, 0, 0, 1, 32'h100,    32'h200,    1,  0, 1, 32'h200,    0, 1, 0, 1);
        vecs[11] = mk(1, 0, 0, 0, 32'h100,    32'h0,      0,  0, 0, 32'h0,      0, 0, 0, 0);
        vecs[12] = mk(1, 0, 0, 0, 32'h100,    32'h0,      0,  1, 0, 32'h100,    0, 0, 1, 0);
        vecs[13] = mk(1, 0, 0, 0, 32'h100,    32'h0,      1,  1, 0, 32'h100,    1, 0, 1, 0);
        vecs[14] = mk(0, 0, 1, 0, 32'h0,      32'h300,    0,  0, 0, 32'h0,      0, 0, 0, 0);
        vecs[15] = mk(0, 0, 1, 0, 32'h0,      32'h300,    0,  1, 0, 32'h300,    0, 0, 0, 1);
        vecs[16] = mk(0, 0, 1, 0, 32'h0,      32'h300,    1,  1, 0, 32'h300,    0, 1, 0, 1);
        vecs[17] = mk(0, 0, 1, 0, 32'h0,      32'h320,    0,  0, 0, 32'h0,      0, 0, 0, 0);
        vecs[18] = mk(0, 0, 1, 0, 32'h0,      32'h320,    0,  1, 0, 32'h320,    0, 0, 0, 1);
        vecs[19] = mk(0, 0, 1, 0, 32'h0,      32'h320,    1,  1, 0, 32'h320,    0, 1, 0, 1);
        vecs[20] = mk(0, 0, 0, 0, 32'h0,      32'h0,      0,  0, 0, 32'h0,      0, 0, 0, 0);

        // Asynchronous reset with no clock edge yet.
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mem_read",  mem_read,   0);
        chk("rst_mem_write", mem_write,  0);
        chk("rst_mem_addr",  mem_addr,   0);
        chk("rst_i_resp",    i_dfp_resp, 0);
        chk("rst_d_resp",    d_dfp_resp, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int k = 0; k < NV; k++) begin
            i_dfp_read  = vecs[k].ir;
            i_dfp_write = vecs[k].iw;
            d_dfp_read  = vecs[k].dr;
            d_dfp_write = vecs[k].dw;
            i_dfp_addr  = vecs[k].ia;
            d_dfp_addr  = vecs[k].da;
            mem_resp    = vecs[k].mresp;
            exp_wd = vecs[k].e_gi ? C_IW : (vecs[k].e_gd ? C_DW : '0);
            @(negedge clk);
            chk($sformatf("v%0d_mem_read", k),  mem_read,    vecs[k].e_mr);
            chk($sformatf("v%0d_mem_write", k), mem_write,   vecs[k].e_mw);
            chk($sformatf("v%0d_mem_addr", k),  mem_addr,    vecs[k].e_ma);
            chk($sformatf("v%0d_mem_wdata", k), mem_wdata,   exp_wd);
            chk($sformatf("v%0d_i_resp", k),    i_dfp_resp,  vecs[k].e_ir);
            chk($sformatf("v%0d_d_resp", k),    d_dfp_resp,  vecs[k].e_dr);
            chk($sformatf("v%0d_i_rdata", k),   i_dfp_rdata, vecs[k].e_gi ? C_MEMR : '0);
            chk($sformatf("v%0d_d_rdata", k),   d_dfp_rdata, vecs[k].e_gd ? C_MEMR : '0);
            tick();
        end
        mem_resp = 1'b0;

        // Reset while D write is outstanding; stale resp must not be forwarded.
        d_dfp_write = 1'b1;
        d_dfp_addr  = 32'h600;
        tick();
        @(negedge clk);
        chk("r5_pre_mem_write", mem_write, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("r5_mem_write", mem_write, 0);
        chk("r5_mem_read",  mem_read,  0);
        chk("r5_mem_addr",  mem_addr,  0);
        d_dfp_write = 1'b0;
        mem_resp    = 1'b1;
        #1;
        chk("r5_stale_d_resp",  d_dfp_resp,  0);
        chk("r5_stale_i_resp",  i_dfp_resp,  0);
        chk("r5_stale_d_rdata", d_dfp_rdata, 0);
        tick();
        mem_resp   = 1'b0;
        rst_n      = 1'b1;
        i_dfp_read = 1'b1;
        i_dfp_addr = 32'h1040;
        @(negedge clk);
        chk("r5_idle_mem_read", mem_read, 0);
        tick();
        @(negedge clk);
        chk("r5_i_mem_read", mem_read, 1);
        chk("r5_i_mem_addr", mem_addr, 32'h1040);
        tick();
        mem_resp = 1'b1;
        @(negedge clk);
        chk("r5_i_resp",  i_dfp_resp,  1);
        chk("r5_i_rdata", i_dfp_rdata, C_MEMR);
        chk("r5_d_resp",  d_dfp_resp,  0);
        tick();
        mem_resp   = 1'b0;
        i_dfp_read = 1'b0;

        // D requests continuously, I joins while D is being served.
        exp_addr[0] = 32'h400;
`ifdef DFP_ARB_RR_EN
        exp_addr[1] = 32'h500;
`else
        exp_addr[1] = 32'h400;
`endif
        exp_addr[2] = 32'h400;
        d_dfp_read = 1'b1;
        d_dfp_addr = 32'h400;
        for (int t = 0; t < 3; t++) begin
            n = 0;
            @(negedge clk);
            while (!mem_read && n < 8) begin
                @(negedge clk);
                n++;
            end
            chk($sformatf("fair%0d_granted", t), mem_read, 1);
            chk($sformatf("fair%0d_addr", t), mem_addr, exp_addr[t]);
            if (t == 0) begin
                tick();
                i_dfp_read = 1'b1;
                i_dfp_addr = 32'h500;
            end
            tick();
            mem_resp = 1'b1;
            @(negedge clk);
            chk($sformatf("fair%0d_i_resp", t), i_dfp_resp, exp_addr[t] == 32'h500);
            chk($sformatf("fair%0d_d_resp", t), d_dfp_resp, exp_addr[t] == 32'h400);
            tick();
            mem_resp = 1'b0;
            if (exp_addr[t] == 32'h500) i_dfp_read = 1'b0;
            if (t == 2) begin
                d_dfp_read = 1'b0;
                i_dfp_read = 1'b0;
            end
        end
        tick();
        @(negedge clk);
        chk("end_mem_read", mem_read, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_dfp_arbiter
`default_nettype wire
